// File: rtl/iomem_nibble_bridge.sv
// iomem_nibble_bridge: serialises a PicoRV32-style iomem transfer into a
// 4-bit framed protocol (command, address, write data / read data) toward the
// pads, with an acknowledge wait bounded by TIMEOUT cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for iomem_valid; request fields latched on accept
// CMD      | one cycle, drives wstrb (0000 for read)
// ADDR     | eight cycles, address nibbles MSB first
// WDATA    | eight cycles, write-data nibbles MSB first (writes only)
// TURN     | one cycle bus turnaround before a read (oe low)
// WAIT_ACK | waits for ext_ack, aborts after TIMEOUT cycles
// RDATA    | seven cycles, captures the remaining read nibbles
// DONE     | one cycle iomem_ready pulse, then back to IDLE
module iomem_nibble_bridge #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        ext_req,
   output logic [3:0]  ext_dout,
   output logic        ext_oe,
   input  logic [3:0]  ext_din,
   input  logic        ext_ack,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_TURN, S_WAIT_ACK, S_RDATA, S_DONE
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [2:0]  nib_q, nib_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rcap_q, rcap_d;
   logic        abort_q, abort_d;

   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        req_q, req_d;
   logic [3:0]  dout_q, dout_d;
   logic        oe_q, oe_d;
   logic        terr_q, terr_d;

   // Nibble i of a word, counting from the most significant nibble.
   function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] i);
      logic [4:0] base;
      base = {~i, 2'b00};
      return w[base +: 4];
   endfunction

   // Next-state logic; pad/core outputs are computed for the next state so they
   // leave the block straight from flops.
   always_comb begin
      state_d    = state_q;
      nib_d      = nib_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      rcap_d     = rcap_q;
      abort_d    = abort_q;

      case (state_q)
         S_IDLE: begin
            if (iomem_valid) begin
               addr_d  = iomem_addr;
               wdata_d = iomem_wdata;
               wstrb_d = iomem_wstrb;
               rcap_d  = '0;
               abort_d = 1'b0;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            nib_d   = '0;
            state_d = S_ADDR;
         end
         S_ADDR: begin
            nib_d = nib_q + 3'd1;
            if (nib_q == 3'd7) begin
               state_d = (wstrb_q == 4'b0000) ? S_TURN : S_WDATA;
            end
         end
         S_WDATA: begin
            nib_d = nib_q + 3'd1;
            if (nib_q == 3'd7) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT_ACK;
            end
         end
         S_TURN: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // ack wins over the abort even on the final allowed cycle
            if (ext_ack) begin
               if (wstrb_q == 4'b0000) begin
                  rcap_d  = {rcap_q[27:0], ext_din};
                  nib_d   = '0;
                  state_d = S_RDATA;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d == WAIT_LIMIT) begin
                  abort_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RDATA: begin
            rcap_d = {rcap_q[27:0], ext_din};
            nib_d  = nib_q + 3'd1;
            if (nib_q == 3'd6) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_d   = (state_d != S_IDLE) && (state_d != S_DONE);
      oe_d    = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_WDATA);
      ready_d = (state_d == S_DONE);
      terr_d  = (state_d == S_DONE) && abort_d;

      case (state_d)
         S_CMD:   dout_d = wstrb_d;
         S_ADDR:  dout_d = nib_sel(addr_d, nib_d);
         S_WDATA: dout_d = nib_sel(wdata_d, nib_d);
         default: dout_d = 4'b0000;
      endcase

      if (state_d != S_DONE) begin
         rdata_d = '0;
      end else if (abort_d) begin
         rdata_d = 32'hFFFF_FFFF;
      end else if (wstrb_q != 4'b0000) begin
         rdata_d = '0;
      end else begin
         rdata_d = rcap_d;
      end
   end

   // State, request latches and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         nib_q      <= '0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rcap_q     <= '0;
         abort_q    <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         req_q      <= 1'b0;
         dout_q     <= '0;
         oe_q       <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         nib_q      <= nib_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rcap_q     <= rcap_d;
         abort_q    <= abort_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         req_q      <= req_d;
         dout_q     <= dout_d;
         oe_q       <= oe_d;
         terr_q     <= terr_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign ext_req     = req_q;
   assign ext_dout    = dout_q;
   assign ext_oe      = oe_q;
   assign timeout_err = terr_q;

endmodule
